// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad supervisor and its lock interface.
// Key codes are active-low one-hot: exactly one cleared bit per pressed key.
package lock_pkg;

  typedef enum logic [1:0] {
    READY,
    ENTRY,
    TIMEOUT,
    LOCKOUT
  } ctrlState_t;

  localparam logic [3:0] NO_KEY = 4'b1111;
  localparam logic [3:0] KEY_0  = 4'b1110;
  localparam logic [3:0] KEY_1  = 4'b1101;
  localparam logic [3:0] KEY_2  = 4'b1011;
  localparam logic [3:0] KEY_3  = 4'b0111;

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser followed by a stability filter for the active-low keypad.
// The filtered key only moves after the synchronised value has been steady long enough.
module key_debouncer
  import lock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] rawKey,
  output logic [3:0] filtered,
  output logic       keyEvent
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] STABLE_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [CW-1:0] stableCnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= NO_KEY;
      sync2 <= NO_KEY;
    end else begin
      sync1 <= rawKey;
      sync2 <= sync1;
    end
  end

  // A pending difference in sync1 means sync2 is about to change, so the run restarts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filtered  <= NO_KEY;
      stableCnt <= '0;
      keyEvent  <= 1'b0;
    end else begin
      keyEvent <= 1'b0;
      if ((sync1 != sync2) || (sync2 == filtered)) begin
        stableCnt <= '0;
      end else if (stableCnt == STABLE_LAST) begin
        filtered  <= sync2;
        stableCnt <= '0;
        keyEvent  <= 1'b1;
      end else begin
        stableCnt <= stableCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lock_access_controller.sv
// Supervisor between the keypad and the lock FSM: debounces keys, raises the
// inactivity timeout, counts consecutive failures and enforces a timed lockout.
module lock_access_controller
  import lock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int MAX_FAILS       = 3,
  parameter int LOCKOUT_CYCLES  = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] rawKey,
  input  logic       lockState,
  input  logic       lockInError,
  input  logic [3:0] bitNumber,
  output logic [3:0] key,
  output logic       timeoutError,
  output logic       lockout,
  output logic [3:0] failCount,
  output logic       keyEvent
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]    FAIL_LIMIT = 4'(MAX_FAILS);

  ctrlState_t    state;
  ctrlState_t    stateNext;
  logic [TW-1:0] idleTimer;
  logic [TW-1:0] idleNext;
  logic [TW-1:0] idleCur;
  logic [LW-1:0] lockTimer;
  logic [LW-1:0] lockNext;
  logic [3:0]    failNext;
  logic [3:0]    failInc;
  logic [3:0]    filtered;
  logic          errPrev;
  logic          lockPrev;
  logic          errRise;
  logic          unlockFall;
  logic          doneNow;
  logic          doneSeen;
  logic          doneNext;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock   (clock),
    .reset   (reset),
    .rawKey  (rawKey),
    .filtered(filtered),
    .keyEvent(keyEvent)
  );

  assign errRise    = lockInError & ~errPrev;
  assign unlockFall = lockPrev & ~lockState;
  assign doneNow    = (bitNumber == 4'd0) && (filtered == NO_KEY);
  assign failInc    = (failCount == 4'hF) ? 4'hF : failCount + 4'd1;

  // The cycle carrying a key event counts as idle cycle zero.
  assign idleCur = keyEvent ? '0 : idleTimer;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= READY;
      idleTimer <= '0;
      lockTimer <= '0;
      failCount <= 4'd0;
      errPrev   <= 1'b0;
      lockPrev  <= 1'b0;
      doneSeen  <= 1'b0;
    end else begin
      state     <= stateNext;
      idleTimer <= idleNext;
      lockTimer <= lockNext;
      failCount <= failNext;
      errPrev   <= lockInError;
      lockPrev  <= lockState;
      doneSeen  <= doneNext;
    end
  end

  // A reported mismatch outranks timer expiry, which outranks sequence completion.
  always_comb begin
    stateNext = state;
    idleNext  = '0;
    lockNext  = '0;
    failNext  = failCount;
    doneNext  = 1'b0;
    case (state)
      READY: begin
        if (keyEvent && (filtered != NO_KEY)) stateNext = ENTRY;
      end
      ENTRY: begin
        idleNext = idleCur + 1'b1;
        doneNext = doneNow;
        if (errRise) begin
          failNext  = failInc;
          stateNext = (failInc == FAIL_LIMIT) ? LOCKOUT : READY;
        end else if (idleCur == IDLE_LAST) begin
          stateNext = TIMEOUT;
        end else if (doneNow && doneSeen) begin
          stateNext = READY;
        end
      end
      TIMEOUT: begin
        if (errRise) begin
          failNext  = failInc;
          stateNext = (failInc == FAIL_LIMIT) ? LOCKOUT : READY;
        end
      end
      LOCKOUT: begin
        if (lockTimer == LOCK_LAST) begin
          failNext  = 4'd0;
          stateNext = READY;
        end else begin
          lockNext = lockTimer + 1'b1;
        end
      end
      default: stateNext = READY;
    endcase
    // A successful unlock wins over a same-cycle failure, so no lockout follows it.
    if (unlockFall && (state != LOCKOUT)) begin
      failNext = 4'd0;
      if (stateNext == LOCKOUT) stateNext = READY;
    end
    if (stateNext != ENTRY) idleNext = '0;
  end

  assign timeoutError = (state == TIMEOUT);
  assign lockout      = (state == LOCKOUT);
  assign key          = lockout ? NO_KEY : filtered;

endmodule

// File: tb/tb_lock_access_controller.sv
// Directed bench for lock_access_controller with short timeout and lockout periods.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_lock_access_controller;
  import lock_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] rawKey;
  logic       lockState;
  logic       lockInError;
  logic [3:0] bitNumber;
  logic [3:0] key;
  logic       timeoutError;
  logic       lockout;
  logic [3:0] failCount;
  logic       keyEvent;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clock = ~clock;

  lock_access_controller #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (20),
    .MAX_FAILS      (3),
    .LOCKOUT_CYCLES (50)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rawKey      (rawKey),
    .lockState   (lockState),
    .lockInError (lockInError),
    .bitNumber   (bitNumber),
    .key         (key),
    .timeoutError(timeoutError),
    .lockout     (lockout),
    .failCount   (failCount),
    .keyEvent    (keyEvent)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Press a key, report a digit mismatch while in ENTRY, then release the key.
  task automatic mismatch(input logic [3:0] code);
    rawKey = code;
    tick(7);
    lockInError = 1'b1;
    tick(1);
    lockInError = 1'b0;
    rawKey = NO_KEY;
    tick(8);
  endtask

  task automatic test_reset;
    tick(2);
    testsRun++; if (key !== NO_KEY) begin testsFailed++; $display("[TB] FAIL reset_key: got %b expected %b", key, NO_KEY); end
    testsRun++; if (timeoutError !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_timeoutError: got %b expected 0", timeoutError); end
    testsRun++; if (lockout !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_lockout: got %b expected 0", lockout); end
    testsRun++; if (failCount !== 4'd0) begin testsFailed++; $display("[TB] FAIL reset_failCount: got %0d expected 0", failCount); end
    testsRun++; if (keyEvent !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_keyEvent: got %b expected 0", keyEvent); end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_bounce;
    int events;
    events = 0;
    bitNumber = 4'd0;
    for (int i = 0; i < 5; i++) begin
      rawKey = (i % 2 == 0) ? KEY_0 : NO_KEY;
      repeat (2) begin tick(1); if (keyEvent === 1'b1) events++; end
    end
    repeat (3) begin tick(1); if (keyEvent === 1'b1) events++; end
    testsRun++; if (key !== NO_KEY) begin testsFailed++; $display("[TB] FAIL bounce_early: got %b expected %b", key, NO_KEY); end
    tick(1);
    if (keyEvent === 1'b1) events++;
    testsRun++; if (key !== KEY_0) begin testsFailed++; $display("[TB] FAIL bounce_settle: got %b expected %b", key, KEY_0); end
    repeat (3) begin tick(1); if (keyEvent === 1'b1) events++; end
    testsRun++; if (events != 1) begin testsFailed++; $display("[TB] FAIL bounce_events: got %0d expected 1", events); end
    rawKey = NO_KEY;
    tick(10);
  endtask

  task automatic test_timeout;
    bitNumber = 4'd1;
    rawKey = KEY_1;
    tick(6);
    testsRun++; if ({keyEvent, key} !== {1'b1, KEY_1}) begin testsFailed++; $display("[TB] FAIL press_latency: got ev=%b key=%b expected ev=1 key=%b", keyEvent, key, KEY_1); end
    rawKey = NO_KEY;
    tick(6);
    testsRun++; if (keyEvent !== 1'b1) begin testsFailed++; $display("[TB] FAIL release_event: got %b expected 1", keyEvent); end
    tick(19);
    testsRun++; if (timeoutError !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_early: got %b expected 0", timeoutError); end
    tick(1);
    testsRun++; if (timeoutError !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout_raise: got %b expected 1", timeoutError); end
    tick(3);
    lockInError = 1'b1;
    tick(1);
    lockInError = 1'b0;
    testsRun++; if (timeoutError !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_ack: got %b expected 0", timeoutError); end
    testsRun++; if (failCount !== 4'd1) begin testsFailed++; $display("[TB] FAIL timeout_failCount: got %0d expected 1", failCount); end
    tick(25);
    testsRun++; if (timeoutError !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_idle_ready: got %b expected 0", timeoutError); end
    bitNumber = 4'd0;
  endtask

  task automatic test_success;
    mismatch(KEY_2);
    testsRun++; if (failCount !== 4'd2) begin testsFailed++; $display("[TB] FAIL success_pre: got %0d expected 2", failCount); end
    lockState = 1'b0;
    tick(1);
    testsRun++; if (failCount !== 4'd0) begin testsFailed++; $display("[TB] FAIL success_clear: got %0d expected 0", failCount); end
    testsRun++; if (lockout !== 1'b0) begin testsFailed++; $display("[TB] FAIL success_lockout: got %b expected 0", lockout); end
    lockState = 1'b1;
    tick(1);
  endtask

  task automatic test_simultaneous;
    logic sawTimeout;
    sawTimeout = 1'b0;
    bitNumber = 4'd1;
    rawKey = KEY_3;
    tick(6);
    rawKey = NO_KEY;
    tick(6);
    repeat (19) begin tick(1); if (timeoutError !== 1'b0) sawTimeout = 1'b1; end
    lockInError = 1'b1;
    repeat (25) begin tick(1); lockInError = 1'b0; if (timeoutError !== 1'b0) sawTimeout = 1'b1; end
    testsRun++; if (sawTimeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL simul_timeoutError: got %b expected 0", sawTimeout); end
    testsRun++; if (failCount !== 4'd1) begin testsFailed++; $display("[TB] FAIL simul_failCount: got %0d expected 1", failCount); end
    bitNumber = 4'd0;
  endtask

  task automatic test_completion;
    logic sawTimeout;
    sawTimeout = 1'b0;
    bitNumber = 4'd0;
    rawKey = KEY_0;
    tick(6);
    rawKey = NO_KEY;
    tick(6);
    repeat (30) begin tick(1); if (timeoutError !== 1'b0) sawTimeout = 1'b1; end
    testsRun++; if (sawTimeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL done_no_timeout: got %b expected 0", sawTimeout); end
    testsRun++; if (failCount !== 4'd1) begin testsFailed++; $display("[TB] FAIL done_failCount: got %0d expected 1", failCount); end
    lockState = 1'b0;
    tick(1);
    lockState = 1'b1;
    tick(1);
    testsRun++; if (failCount !== 4'd0) begin testsFailed++; $display("[TB] FAIL done_unlock_clear: got %0d expected 0", failCount); end
  endtask

  task automatic test_lockout;
    mismatch(KEY_0);
    mismatch(KEY_1);
    testsRun++; if ({lockout, failCount} !== {1'b0, 4'd2}) begin testsFailed++; $display("[TB] FAIL lockout_pre: got lockout=%b fc=%0d expected lockout=0 fc=2", lockout, failCount); end
    rawKey = KEY_2;
    tick(7);
    lockInError = 1'b1;
    tick(1);
    lockInError = 1'b0;
    testsRun++; if (lockout !== 1'b1) begin testsFailed++; $display("[TB] FAIL lockout_enter: got %b expected 1", lockout); end
    testsRun++; if (failCount !== 4'd3) begin testsFailed++; $display("[TB] FAIL lockout_failCount: got %0d expected 3", failCount); end
    testsRun++; if (key !== NO_KEY) begin testsFailed++; $display("[TB] FAIL lockout_mask_held: got %b expected %b", key, NO_KEY); end
    rawKey = KEY_1;
    tick(6);
    testsRun++; if (key !== NO_KEY) begin testsFailed++; $display("[TB] FAIL lockout_mask_press: got %b expected %b", key, NO_KEY); end
    lockInError = 1'b1;
    tick(1);
    lockInError = 1'b0;
    rawKey = NO_KEY;
    tick(12);
    lockState = 1'b0;
    tick(1);
    lockState = 1'b1;
    tick(29);
    testsRun++; if ({lockout, failCount} !== {1'b1, 4'd3}) begin testsFailed++; $display("[TB] FAIL lockout_hold: got lockout=%b fc=%0d expected lockout=1 fc=3", lockout, failCount); end
    tick(1);
    testsRun++; if (lockout !== 1'b0) begin testsFailed++; $display("[TB] FAIL lockout_end: got %b expected 0", lockout); end
    testsRun++; if (failCount !== 4'd0) begin testsFailed++; $display("[TB] FAIL lockout_end_failCount: got %0d expected 0", failCount); end
  endtask

  task automatic test_reset_lockout;
    mismatch(KEY_0);
    mismatch(KEY_0);
    rawKey = KEY_0;
    tick(7);
    lockInError = 1'b1;
    tick(1);
    lockInError = 1'b0;
    testsRun++; if (lockout !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_lockout_enter: got %b expected 1", lockout); end
    tick(24);
    #2 reset = 1'b1;
    #1;
    testsRun++; if ({key, lockout, failCount, timeoutError, keyEvent} !== {NO_KEY, 1'b0, 4'd0, 1'b0, 1'b0})
      begin testsFailed++; $display("[TB] FAIL rst_async: got key=%b lo=%b fc=%0d to=%b ev=%b expected key=1111 lo=0 fc=0 to=0 ev=0", key, lockout, failCount, timeoutError, keyEvent); end
    rawKey = NO_KEY;
    @(negedge clock);
    reset = 1'b0;
    rawKey = KEY_3;
    tick(5);
    testsRun++; if (key !== NO_KEY) begin testsFailed++; $display("[TB] FAIL rst_track_early: got %b expected %b", key, NO_KEY); end
    tick(1);
    testsRun++; if ({keyEvent, key} !== {1'b1, KEY_3}) begin testsFailed++; $display("[TB] FAIL rst_track: got ev=%b key=%b expected ev=1 key=%b", keyEvent, key, KEY_3); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    rawKey      = NO_KEY;
    lockState   = 1'b1;
    lockInError = 1'b0;
    bitNumber   = 4'd0;
    test_reset();
    test_bounce();
    test_timeout();
    test_success();
    test_simultaneous();
    test_completion();
    test_lockout();
    test_reset_lockout();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
